// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving the select of an N-to-1 data mux; RR_SELECT_ARBITER_LOCK_EN adds a burst lock input.
// Latency: one cycle from request in IDLE to out_valid; back-to-back grants give one transfer per cycle.
// Backpressure: sel/grant held while out_ready is low; dropping the granted request without accept abandons it.
module rr_select_arbiter #(
    parameter int NUM_INPUTS = 8,
    parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_INPUTS-1:0] req,
    input  logic                  out_ready,
`ifdef RR_SELECT_ARBITER_LOCK_EN
    input  logic                  lock,
`endif
    output logic [SEL_WIDTH-1:0]  sel,
    output logic [NUM_INPUTS-1:0] grant,
    output logic                  out_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [SEL_WIDTH-1:0] LAST  = SEL_WIDTH'(NUM_INPUTS - 1);
    localparam logic [SEL_WIDTH:0]   COUNT = (SEL_WIDTH + 1)'(NUM_INPUTS);

    state_t                  state;
    state_t                  state_nxt;
    logic [SEL_WIDTH-1:0]    ptr;
    logic [SEL_WIDTH-1:0]    ptr_nxt;
    logic [SEL_WIDTH-1:0]    sel_nxt;
    logic [NUM_INPUTS-1:0]   grant_nxt;
    logic                    out_valid_nxt;

    logic                    accept;
    logic                    burst_hold;
    logic [SEL_WIDTH-1:0]    sel_inc;
    logic [SEL_WIDTH-1:0]    arb_base;
    logic [SEL_WIDTH-1:0]    arb_idx;
    logic [SEL_WIDTH:0]      arb_pos;
    logic                    arb_found;

    function automatic logic [NUM_INPUTS-1:0] onehot(input logic [SEL_WIDTH-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    assign accept  = (state == GRANT) && out_ready;
    assign sel_inc = (sel == LAST) ? '0 : sel + 1'b1;

`ifdef RR_SELECT_ARBITER_LOCK_EN
    assign burst_hold = lock && req[sel];
`else
    assign burst_hold = 1'b0;
`endif

    // In GRANT the only re-arbitration is on accept, which starts just past the current winner.
    assign arb_base = (state == GRANT) ? sel_inc : ptr;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_pos   = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            arb_pos = {1'b0, arb_base} + (SEL_WIDTH + 1)'(k);
            if (arb_pos >= COUNT) begin
                arb_pos = arb_pos - COUNT;
            end
            if (!arb_found && req[arb_pos[SEL_WIDTH-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_pos[SEL_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        sel_nxt       = sel;
        grant_nxt     = grant;
        out_valid_nxt = out_valid;
        unique case (state)
            IDLE: begin
                if (arb_found) begin
                    state_nxt     = GRANT;
                    sel_nxt       = arb_idx;
                    grant_nxt     = onehot(arb_idx);
                    out_valid_nxt = 1'b1;
                end
            end
            GRANT: begin
                if (accept && !burst_hold) begin
                    ptr_nxt = sel_inc;
                    if (arb_found) begin
                        sel_nxt   = arb_idx;
                        grant_nxt = onehot(arb_idx);
                    end else begin
                        state_nxt     = IDLE;
                        grant_nxt     = '0;
                        out_valid_nxt = 1'b0;
                    end
                end else if (!accept && !req[sel]) begin
                    state_nxt     = IDLE;
                    grant_nxt     = '0;
                    out_valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            grant     <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            sel       <= sel_nxt;
            grant     <= grant_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    assert property (@(posedge clk) disable iff (!rst_n) sel <= LAST);
    assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> (grant == (NUM_INPUTS'(1) << sel)));
    assert property (@(posedge clk) disable iff (!rst_n) !out_valid |-> (grant == '0));

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Bench for rr_select_arbiter: directed scenarios plus randomized traffic on an 8-input and a 5-input instance.
module tb_rr_select_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       lock;
    logic [7:0] req8;
    logic       rdy8;
    logic [2:0] sel8;
    logic [7:0] gnt8;
    logic       vld8;
    logic [4:0] req5;
    logic       rdy5;
    logic [2:0] sel5;
    logic [4:0] gnt5;
    logic       vld5;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: granted source (-1 when idle) and priority pointer per instance.
    int g8 = -1;
    int p8 = 0;
    int g5 = -1;
    int p5 = 0;
    int acc8 = -1;
    int acc5 = -1;

    rr_select_arbiter #(.NUM_INPUTS(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req8),
        .out_ready (rdy8),
`ifdef RR_SELECT_ARBITER_LOCK_EN
        .lock      (lock),
`endif
        .sel       (sel8),
        .grant     (gnt8),
        .out_valid (vld8)
    );

    rr_select_arbiter #(.NUM_INPUTS(5)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req5),
        .out_ready (rdy5),
`ifdef RR_SELECT_ARBITER_LOCK_EN
        .lock      (lock),
`endif
        .sel       (sel5),
        .grant     (gnt5),
        .out_valid (vld5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int n, input int base, input logic [7:0] r);
        for (int k = 0; k < n; k++) begin
            if (r[(base + k) % n]) return (base + k) % n;
        end
        return -1;
    endfunction

    task automatic advance(input int n, input logic [7:0] r, input logic rdy, input logic lk,
                           inout int g, inout int p);
        if (!rst_n) begin
            g = -1;
            p = 0;
        end else if (g < 0) begin
            g = pick(n, p, r);
        end else if (rdy) begin
            if (!(lk && r[g])) begin
                p = (g + 1) % n;
                g = pick(n, p, r);
            end
        end else if (!r[g]) begin
            g = -1;
        end
    endtask

    task automatic check_outputs();
        check("vld8", vld8, g8 >= 0);
        if (g8 >= 0) begin
            check("sel8", sel8, g8);
            check("gnt8", gnt8, 1 << g8);
        end else begin
            check("gnt8_idle", gnt8, 0);
        end
        check("vld5", vld5, g5 >= 0);
        check("sel5_range", sel5 <= 3'd4, 1);
        if (g5 >= 0) begin
            check("sel5", sel5, g5);
            check("gnt5", gnt5, 1 << g5);
        end else begin
            check("gnt5_idle", gnt5, 0);
        end
    endtask

    task automatic tick();
        logic lk;
        lk = 1'b0;
`ifdef RR_SELECT_ARBITER_LOCK_EN
        lk = lock;
`endif
        acc8 = (rst_n && g8 >= 0 && rdy8) ? g8 : -1;
        acc5 = (rst_n && g5 >= 0 && rdy5) ? g5 : -1;
        advance(8, req8, rdy8, lk, g8, p8);
        advance(5, {3'b000, req5}, rdy5, lk, g5, p5);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0;
        lock  = 1'b0;
        req8  = '0;
        req5  = '0;
        rdy8  = 1'b0;
        rdy5  = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check("rst_sel", sel8, 0);
        check("rst_vld", vld8, 0);
        rst_n = 1'b1;

        // Single request, then accept with the request dropped; pointer lands on 3.
        req8 = 8'h04; rdy8 = 1'b1;
        tick();
        check("single_sel", sel8, 2);
        check("single_gnt", gnt8, 8'h04);
        req8 = 8'h00;
        tick();
        check("single_drop_vld", vld8, 0);
        req8 = 8'h09; rdy8 = 1'b0;
        tick();
        check("ptr_after_accept", sel8, 3);

        // All requesting: strict rotation, one transfer per cycle.
        rst_n = 1'b0; req8 = '0; tick(); rst_n = 1'b1;
        req8 = 8'hFF; rdy8 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("rr_seq", sel8, i % 8);
            check("rr_vld", vld8, 1);
        end

        // Backpressure holds sel, release moves to the next requester.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req8 = 8'h12; rdy8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", sel8, 1);
        end
        rdy8 = 1'b1;
        tick();
        check("bp_next", sel8, 4);

        // Non-power-of-two wrap on the 5-input instance.
        rst_n = 1'b0; rdy8 = 1'b0; req8 = '0; tick(); rst_n = 1'b1;
        req5 = 5'b01000; rdy5 = 1'b1;
        tick();
        check("w5_first", sel5, 3);
        req5 = 5'b00011;
        tick();
        check("w5_wrap", sel5, 0);
        tick();
        check("w5_next", sel5, 1);
        req5 = '0;
        tick();

        // Abort: granted request withdrawn under backpressure.
        req8 = 8'h08; rdy8 = 1'b0;
        tick();
        check("abort_sel", sel8, 3);
        req8 = 8'h00;
        tick();
        check("abort_vld", vld8, 0);
        check("abort_gnt", gnt8, 0);

        // Reset in the middle of a grant stream restarts priority from 0.
        req8 = 8'hFF; rdy8 = 1'b1;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        check("midrst_vld", vld8, 0);
        check("midrst_gnt", gnt8, 0);
        check("midrst_sel", sel8, 0);
        rst_n = 1'b1;
        tick();
        check("midrst_restart", sel8, 0);

`ifdef RR_SELECT_ARBITER_LOCK_EN
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req8 = 8'h03; rdy8 = 1'b1; lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lock_hold", sel8, 0);
        end
        lock = 1'b0;
        tick();
        check("lock_release", sel8, 1);
`endif

        // Randomized traffic: sources hold requests until accepted, with rare aborts and resets.
        for (int c = 0; c < 3000; c++) begin
            rdy8  = ($urandom_range(0, 9) < 7);
            rdy5  = ($urandom_range(0, 9) < 6);
            rst_n = ($urandom_range(0, 299) != 0);
`ifdef RR_SELECT_ARBITER_LOCK_EN
            lock = ($urandom_range(0, 3) == 0);
`endif
            for (int i = 0; i < 8; i++) begin
                if (req8[i] && i != acc8) begin
                    if ($urandom_range(0, 59) == 0) req8[i] = 1'b0;
                end else begin
                    req8[i] = ($urandom_range(0, 3) == 0);
                end
            end
            for (int i = 0; i < 5; i++) begin
                if (req5[i] && i != acc5) begin
                    if ($urandom_range(0, 59) == 0) req5[i] = 1'b0;
                end else begin
                    req5[i] = ($urandom_range(0, 2) == 0);
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_select_arbiter.md
Name: rr_select_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the generic N-to-1 data multiplexer. It drives that mux's select line.
- Takes a request vector from NUM_INPUTS sources and grants one source at a time. Its registered sel output feeds the mux select input; the mux output data is qualified by this block's out_valid.
- Holds sel stable across downstream backpressure and supports back-to-back grants.

Parameters:
- NUM_INPUTS, 8, number of requesting sources; must be >= 2.
- SEL_WIDTH, $clog2(NUM_INPUTS), width of sel; matches the mux select width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  NUM_INPUTS  request per source. Source i holds req[i] high until its transfer is accepted.
- out_ready  input  1  downstream accepts the muxed word when out_valid && out_ready.
- sel  output  SEL_WIDTH  registered index of the granted source; drives the mux select.
- grant  output  NUM_INPUTS  registered one-hot grant. grant[i] && out_ready is source i's completion strobe.
- out_valid  output  1  registered; high when sel/grant are valid and mux output is a live word.

Behaviour:
- Reset (rst_n low at posedge clk): sel=0, grant=0, out_valid=0, priority pointer ptr=0, state=IDLE. Reset wins over every other event in the same cycle and abandons any grant in flight.
- State IDLE:
  - out_valid=0 and grant=0.
  - If any req bit is high, the winner is the first set bit scanning ptr, ptr+1, … NUM_INPUTS-1, 0, …, ptr-1.
  - On the next edge: sel=winner, grant=one-hot(winner), out_valid=1, state GRANT.
  - Latency from req rising in IDLE to out_valid is 1 cycle.
- State GRANT:
  - sel and grant are held constant while out_ready is low.
  - Accept (out_valid && out_ready): ptr becomes sel+1, wrapping from NUM_INPUTS-1 to 0.
  - Same-edge re-arbitration on accept: the arbiter immediately re-arbitrates over req sampled in the accept cycle, using the new ptr.
    - The accepted source is lowest priority, so it is re-granted only if no other source requests.
    - If any request is present, stay in GRANT with the new sel/grant and out_valid kept at 1, giving 1 transfer per cycle.
    - If no request is present, go to IDLE with out_valid=0 and grant=0.
  - Abort (req[sel] falls while in GRANT without accept; a protocol violation): next edge out_valid=0, grant=0, ptr unchanged, state IDLE. The arbiter re-arbitrates from IDLE on the following cycle.
  - Simultaneous accept and falling req[sel] in the same cycle counts as an accept.
- Only index values 0..NUM_INPUTS-1 are ever driven on sel, including for non-power-of-two NUM_INPUTS. The pointer wrap uses compare-to-(NUM_INPUTS-1), not natural overflow.
- grant always has at most one bit set and equals one-hot(sel) whenever out_valid=1. grant is 0 whenever out_valid=0.
- Fairness: with all sources requesting continuously, each source is granted exactly once in every NUM_INPUTS consecutive accepts.

Optional Feature:
- Macro: RR_SELECT_ARBITER_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit).
  - If lock=1 during an accept and req[sel] is still high, the same source is re-granted and ptr is not advanced. This supports multi-beat bursts.
  - lock is ignored in IDLE and on abort.
- When not defined: no lock port; pure round-robin as above.

Test Plan:
- Reset, then req=8'b0000_0100, out_ready=1 → 1 cycle later sel=2, grant=8'h04, out_valid=1. After the accept with req dropped, out_valid=0 and ptr=3.
- req=8'hFF held, out_ready=1 for 16 cycles → sel sequence 0,1,…,7,0,…,7 with out_valid continuously 1. Each grant is one-hot.
- Backpressure: req=8'b0001_0010, out_ready=0 for 5 cycles → sel=1 stable all 5 cycles. Raise out_ready for 1 cycle → next sel=4.
- Wrap / non-power-of-two: NUM_INPUTS=5, ptr at 4 after granting index 3, req=5'b00011 → next sel=0, then 1. sel never exceeds 4.
- Abort and reset mid-operation:
  - Granted sel=3, drop req[3] with out_ready=0 → next cycle out_valid=0, grant=0.
  - Assert rst_n=0 during GRANT → next edge all outputs 0 and the next grant starts from index 0.
- With RR_SELECT_ARBITER_LOCK_EN: req=8'b0000_0011, lock=1 for 3 accepts → sel=0,0,0. Then lock=0 → sel=1.
